// File: rtl/i2c_target_regif_pkg.sv
// Shared definitions for the I2C target register interface: state encodings,
// the default device address and the address-match helper.
package i2c_target_regif_pkg;

    localparam logic [6:0] DefDevAddr = 7'h1D;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StDevAddr = 4'd1,
        StAddrAck = 4'd2,
        StRegAddr = 4'd3,
        StRegAck  = 4'd4,
        StWrData  = 4'd5,
        StWrAck   = 4'd6,
        StRdData  = 4'd7,
        StRdAck   = 4'd8,
        StIgnore  = 4'd9
    } state_e;

    // General call (address 0) is never acknowledged, whatever the target address.
    function automatic logic addr_match(logic [7:0] addr_byte, logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr) && (addr_byte[7:1] != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_target_regif_if.sv
// Register-bank side of the I2C target: pointer, write strobe/data and read data.
interface i2c_target_regif_if;

    logic [7:0] reg_addr;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    modport master (
        output reg_addr,
        output reg_wr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wr,
        input  reg_wdata,
        output reg_rdata
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the system clock domain and flags SCL edges and
// START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // [1:0] synchroniser, [2] history. Reset high so an idle bus gives no false START.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign sda_s    = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target responder: decodes device address, register pointer and
// auto-incrementing multi-byte writes/reads onto a synchronous register bank.
module i2c_target_regif
    import i2c_target_regif_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DefDevAddr,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i2c_scl,
    inout  wire                 i2c_sda,
    i2c_target_regif_if.master  bus,
    output logic                o_busy,
    output logic                o_stop,
    output logic [7:0]          o_status
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_bus_sync u_bus_sync (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .scl      (i2c_scl),
        .sda      (i2c_sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       rw_q;
    logic       phase_q;
    logic       sda_oe_q;
    logic [7:0] ptr_q;
    logic       reg_wr_q;
    logic [7:0] reg_wdata_q;
    logic       inc_q;
    logic       busy_q;
    logic       stop_q;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q[6:0], sda_s};

    // phase_q: in ACK states, set once ACK is driven; in RD_DATA, set after bit 0
    // has been sampled; in RD_ACK, set when the master acked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd7;
            shift_q     <= 8'h00;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            ptr_q       <= 8'h00;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= 8'h00;
            inc_q       <= 1'b0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            reg_wr_q <= 1'b0;
            stop_q   <= 1'b0;
            if (inc_q) begin
                ptr_q <= ptr_q + 8'd1;
                inc_q <= 1'b0;
            end

            if (stop) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                stop_q   <= busy_q;
                busy_q   <= 1'b0;
            end else if (start) begin
                state_q   <= StDevAddr;
                bit_cnt_q <= 3'd7;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    StDevAddr, StRegAddr, StWrData: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (bit_cnt_q != 3'd0) begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end else begin
                                phase_q <= 1'b0;
                                if (state_q == StDevAddr) begin
                                    if (addr_match(rx_byte, DEV_ADDR)) begin
                                        state_q <= StAddrAck;
                                        busy_q  <= 1'b1;
                                        rw_q    <= rx_byte[0];
                                    end else begin
                                        state_q <= StIgnore;
                                    end
                                end else if (state_q == StRegAddr) begin
                                    ptr_q   <= rx_byte;
                                    state_q <= StRegAck;
                                end else begin
                                    reg_wdata_q <= rx_byte;
                                    reg_wr_q    <= 1'b1;
                                    inc_q       <= AUTO_INC;
                                    state_q     <= StWrAck;
                                end
                            end
                        end
                    end

                    StAddrAck, StRegAck, StWrAck: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                phase_q   <= 1'b0;
                                bit_cnt_q <= 3'd7;
                                if (state_q == StAddrAck && rw_q) begin
                                    // Releasing ACK and driving data bit 7 share this edge.
                                    shift_q  <= bus.reg_rdata;
                                    sda_oe_q <= ~bus.reg_rdata[7];
                                    state_q  <= StRdData;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= (state_q == StAddrAck) ? StRegAddr : StWrData;
                                end
                            end
                        end
                    end

                    StRdData: begin
                        if (scl_rise) begin
                            if (bit_cnt_q == 3'd0) begin
                                phase_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end
                        end else if (scl_fall) begin
                            if (phase_q) begin
                                sda_oe_q <= 1'b0;
                                phase_q  <= 1'b0;
                                state_q  <= StRdAck;
                            end else begin
                                sda_oe_q <= ~shift_q[bit_cnt_q];
                            end
                        end
                    end

                    StRdAck: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                phase_q <= 1'b1;
                                if (AUTO_INC) begin
                                    ptr_q <= ptr_q + 8'd1;
                                end
                            end else begin
                                state_q <= StIgnore;
                                busy_q  <= 1'b0;
                            end
                        end else if (scl_fall && phase_q) begin
                            shift_q   <= bus.reg_rdata;
                            sda_oe_q  <= ~bus.reg_rdata[7];
                            bit_cnt_q <= 3'd7;
                            phase_q   <= 1'b0;
                            state_q   <= StRdData;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

    assign i2c_sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign bus.reg_addr  = ptr_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign o_busy        = busy_q;
    assign o_stop        = stop_q;
    assign o_status      = {4'b0000, state_q};

endmodule
